// File: rtl/config_latch_bank_if.sv
// Request/readback port of the configuration latch bank.
// The master side issues row requests; the slave side is the bank.
interface config_latch_bank_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int BL_WIDTH   = 16
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic                  cfg_we;
  logic [ADDR_WIDTH-1:0] cfg_addr;
  logic [BL_WIDTH-1:0]   cfg_wdata;
  logic                  cfg_lock;
  logic                  rd_valid;
  logic [BL_WIDTH-1:0]   rd_data;
  logic                  err;

  modport master (
    output cfg_valid,
    output cfg_we,
    output cfg_addr,
    output cfg_wdata,
    output cfg_lock,
    input  cfg_ready,
    input  rd_valid,
    input  rd_data,
    input  err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_we,
    input  cfg_addr,
    input  cfg_wdata,
    input  cfg_lock,
    output cfg_ready,
    output rd_valid,
    output rd_data,
    output err
  );
endinterface

// File: rtl/config_latch_bank.sv
// WL_COUNT x BL_WIDTH configuration latch array with sequenced
// bit-line setup / word-line strobe writes and row readback.
module config_latch_bank #(
  parameter int WL_COUNT   = 8,
  parameter int BL_WIDTH   = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  config_latch_bank_if.slave           cfg,
  output logic [WL_COUNT*BL_WIDTH-1:0] Q,
  output logic [WL_COUNT*BL_WIDTH-1:0] Qb
);
  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    READ
  } state_t;

  localparam logic [ADDR_WIDTH:0] ROW_LIM =
    (ADDR_WIDTH+1)'(WL_COUNT);

  state_t                state;
  logic                  ready;
  logic                  rd_valid;
  logic                  err;
  logic [BL_WIDTH-1:0]   rd_data;
  logic [ADDR_WIDTH-1:0] addr;
  logic [BL_WIDTH-1:0]   bl;
  logic [WL_COUNT-1:0]   wl;
  logic [BL_WIDTH-1:0]   rows [WL_COUNT];
  logic                  accept;
  logic                  bad;

  assign accept = cfg.cfg_valid && ready;
  assign bad    = ({1'b0, cfg.cfg_addr} >= ROW_LIM)
               || (cfg.cfg_we && cfg.cfg_lock);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ready    <= 1'b0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
      rd_data  <= '0;
      addr     <= '0;
      bl       <= '0;
      wl       <= '0;
      for (int r = 0; r < WL_COUNT; r++)
        rows[r] <= '0;
    end else begin
      rd_valid <= 1'b0;
      err      <= 1'b0;
      unique case (state)
        IDLE: begin
          ready <= 1'b1;
          if (accept) begin
            addr <= cfg.cfg_addr;
            bl   <= cfg.cfg_wdata;
            if (bad) begin
              err <= 1'b1;
            end else if (cfg.cfg_we) begin
              state <= SETUP;
              ready <= 1'b0;
            end else begin
              state <= READ;
              ready <= 1'b0;
            end
          end
        end
        SETUP: begin
          for (int r = 0; r < WL_COUNT; r++)
            wl[r] <= (addr == ADDR_WIDTH'(r));
          state <= STROBE;
        end
        STROBE: begin
          // only the strobed word-line captures the bit-lines
          for (int r = 0; r < WL_COUNT; r++)
            if (wl[r]) rows[r] <= bl;
          wl    <= '0;
          state <= IDLE;
          ready <= 1'b1;
        end
        READ: begin
          rd_data  <= rows[addr];
          rd_valid <= 1'b1;
          ready    <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < WL_COUNT; r++) begin : g_q
    assign Q[r*BL_WIDTH +: BL_WIDTH] = rows[r];
  end

  assign Qb = ~Q;

  assign cfg.cfg_ready = ready;
  assign cfg.rd_valid  = rd_valid;
  assign cfg.rd_data   = rd_data;
  assign cfg.err       = err;
endmodule

// File: doc/config_latch_bank.md
# config_latch_bank

Parametrised configuration-memory bank: a WL_COUNT × BL_WIDTH array of configuration latches, written and read back one word-line (row) at a time through a valid/ready request port. It replaces per-bit hand-instantiated latch cells in fabric tiles with a single array. It sequences the bit-line setup and word-line strobe internally, supports a write lock, and provides row readback for configuration verification. Q/Qb drive the fabric routing and LUT configuration inputs.

## Interface
- WL_COUNT, 8, number of word-lines (rows); ≥ 1
- BL_WIDTH, 16, bits per row (bit-lines); ≥ 1
- ADDR_WIDTH, 3, row address width; must satisfy 2^ADDR_WIDTH ≥ WL_COUNT

- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low reset
- cfg_valid  in  1  request valid
- cfg_ready  out  1  bank idle and able to accept a request
- cfg_we  in  1  1 = write row, 0 = read row
- cfg_addr  in  ADDR_WIDTH  target row
- cfg_wdata  in  BL_WIDTH  write data
- cfg_lock  in  1  when 1, write requests are rejected; reads are still allowed
- rd_valid  out  1  one-cycle pulse; rd_data holds valid read data
- rd_data  out  BL_WIDTH  readback row
- err  out  1  one-cycle pulse; accepted request was rejected
- Q  out  WL_COUNT*BL_WIDTH  latch contents; row r, bit b at Q[r*BL_WIDTH+b]
- Qb  out  WL_COUNT*BL_WIDTH  bitwise complement of Q at all times

## Operation
- Handshake: a request is accepted on a rising edge where cfg_valid && cfg_ready. cfg_ready = 1 only in IDLE and not in reset. Inputs are sampled only at acceptance; changes afterwards are ignored.
- FSM states:
  - IDLE → SETUP on an accepted valid write.
  - IDLE → READ on an accepted valid read.
  - IDLE → IDLE on an accepted rejected request.
  - SETUP → STROBE → IDLE unconditionally.
  - READ → IDLE unconditionally.
- Rejection: err pulses when cfg_addr ≥ WL_COUNT (any operation), or when cfg_we = 1 and cfg_lock = 1 at acceptance. No array change occurs, no rd_valid pulse occurs, and the FSM stays IDLE.
- SETUP: the sampled data is latched into the internal bit-line register, and the row address is decoded. No array change.
- STROBE: the decoded one-hot word-line is asserted for this cycle only. The addressed row takes the bit-line register at the end of STROBE. All other rows hold.
- READ: rd_data ← addressed row. rd_valid pulses on the following cycle. rd_data holds its last value until the next read.
- cfg_lock is sampled only at acceptance. Asserting it during SETUP/STROBE does not abort a write in progress.
- Qb is combinationally ~Q. It is never independently stored.

## Timing
- Reset (reset = 0 at an edge):
  - Q = 0 and Qb = all ones.
  - rd_data = 0; rd_valid = 0; err = 0; cfg_ready = 0.
  - FSM → IDLE.
  - cfg_ready = 1 in the first cycle after reset is sampled high.
- Reset mid-operation aborts a write or read. The whole array clears; no rd_valid or err is produced.
- Write, accepted at edge k:
  - SETUP during cycle k..k+1; STROBE during k+1..k+2.
  - Q updated after edge k+2.
  - cfg_ready = 0 from k to k+2 and 1 again after k+2.
  - Throughput: one write per 3 cycles.
- Read, accepted at edge k:
  - READ during k..k+1.
  - rd_valid = 1 and rd_data valid after edge k+1, for one cycle.
  - cfg_ready = 1 again after k+1.
  - Back-to-back reads: one per 2 cycles.
- Reject, accepted at edge k: err = 1 after edge k for one cycle. cfg_ready stays 1, so a new request may be accepted at k+1.
- A read of a row issued after a write completes (cfg_ready high again) returns the new data. No forwarding is needed, since requests never overlap.
- All outputs except Qb are registered.

## Test plan
- Reset: hold reset = 0 for 2 cycles, then release:
  - Q = 0 and Qb = 0xFFFF per row (defaults).
  - cfg_ready = 0 during reset and 1 one cycle after release.
- Write/readback, default parameters:
  - Write row 3 = 0xA5C3 → Q[63:48] = 0xA5C3 two edges after acceptance; other rows stay 0.
  - Read row 3 → rd_valid one cycle after acceptance, with rd_data = 0xA5C3.
- All rows: write row r = 0x1111*r for r = 0..7, then read all rows back → each returns its value; Qb = ~Q throughout.
- Lock and range:
  - cfg_lock = 1, write row 2 = 0xFFFF → err pulses one cycle later; row 2 unchanged; no rd_valid.
  - Read addr 7 while locked → succeeds.
  - WL_COUNT = 6, access addr 6 → err.
- Handshake: hold cfg_valid = 1 with a stream of writes → exactly one acceptance every 3 cycles. Changing cfg_wdata during SETUP does not affect the stored row.
- Reset mid-write: assert reset during STROBE of a write of 0xBEEF to row 1 → Q = 0 after the reset edge; no err or rd_valid afterwards.
